// File: rtl/mul_wide_seq.sv
// mul_wide_seq
//   Sequential wide-operand multiplier. Two NUM_LIMBS*17-bit unsigned operands
//   are split into 17-bit limbs. All NUM_LIMBS^2 limb products go through one
//   shared 17x17 multiplier, one product per cycle, and are shift-accumulated
//   into an exact 2*W-bit result. Valid/ready handshakes on input and output.
//
// Build option
//   MUL_WIDE_SEQ_PIPE_EN  registers the limb product together with its limb
//                         shift before it is accumulated, and adds one DRAIN
//                         cycle. This shortens the multiply-to-accumulate path.
//                         Results are identical in both builds.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous reset, active low
//   i_in_valid   operand pair valid
//   o_in_ready   operands accepted (high only in IDLE)
//   i_in_a       multiplicand, W bits, unsigned
//   i_in_b       multiplier, W bits, unsigned
//   o_out_valid  result valid, held until accepted
//   i_out_ready  consumer accepts the result
//   o_out_c      product, 2*W bits
//   o_busy       high in any state other than IDLE
//
// States
//   S_IDLE  | waiting for operands, o_in_ready=1
//   S_MUL   | issuing one limb product per cycle, j inner, i outer
//   S_DRAIN | accumulating the last registered product (pipelined build only)
//   S_DONE  | o_out_valid=1, result held until i_out_ready
module mul_wide_seq #(
  parameter  int NUM_LIMBS = 4,
  localparam int W         = NUM_LIMBS * 17,
  localparam int CW        = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_in_a,
  input  logic [W-1:0]  i_in_b,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [CW-1:0] o_out_c,
  output logic          o_busy
);

  localparam int IW = $clog2(NUM_LIMBS);
  localparam logic [IW-1:0] LAST = IW'(NUM_LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [CW-1:0]  r_acc;
  logic [IW-1:0]  r_i;
  logic [IW-1:0]  r_j;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [16:0]    w_a_limb;
  logic [16:0]    w_b_limb;
  logic [33:0]    w_p;
  logic [IW:0]    w_sum;
  logic [CW-1:0]  w_term;

  assign w_a_limb = r_a[int'(r_i) * 17 +: 17];
  assign w_b_limb = r_b[int'(r_j) * 17 +: 17];
  // The single shared 17x17 unsigned multiplier.
  assign w_p      = 34'(w_a_limb) * 34'(w_b_limb);
  assign w_sum    = {1'b0, r_i} + {1'b0, r_j};

`ifdef MUL_WIDE_SEQ_PIPE_EN
  logic [33:0]    r_p;
  logic [IW:0]    r_sh;
  // r_p is cleared on accept, so the first MUL cycle adds zero harmlessly.
  assign w_term = CW'(r_p) << (17 * int'(r_sh));
`else
  assign w_term = CW'(w_p) << (17 * int'(w_sum));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MUL_WIDE_SEQ_PIPE_EN
      r_p         <= '0;
      r_sh        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_in_a;
            r_b        <= i_in_b;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_MUL;
`ifdef MUL_WIDE_SEQ_PIPE_EN
            r_p        <= '0;
            r_sh       <= '0;
`endif
          end
        end

        S_MUL: begin
          r_acc <= r_acc + w_term;
`ifdef MUL_WIDE_SEQ_PIPE_EN
          r_p   <= w_p;
          r_sh  <= w_sum;
`endif
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              r_i <= '0;
`ifdef MUL_WIDE_SEQ_PIPE_EN
              r_state     <= S_DRAIN;
`else
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
`endif
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end

        S_DRAIN: begin
          r_acc       <= r_acc + w_term;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end

        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            // Raised here so it is seen the cycle after the output handshake.
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_c     = r_acc;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mul_wide_seq.sv
module tb_mul_wide_seq;

  localparam int N  = 4;
  localparam int W  = N * 17;
  localparam int CW = 2 * W;
`ifdef MUL_WIDE_SEQ_PIPE_EN
  localparam int LAT = N * N + 2;
`else
  localparam int LAT = N * N + 1;
`endif
  localparam int PER = LAT + 1;

  logic          clk;
  logic          rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_in_a;
  logic [W-1:0]  i_in_b;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [CW-1:0] o_out_c;
  logic          o_busy;

  int n_checks;
  int n_err;

  mul_wide_seq #(.NUM_LIMBS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_a      (i_in_a),
    .i_in_b      (i_in_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_c     (o_out_c),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [95:0] t;
    int m;
    t = {$urandom(), $urandom(), $urandom()};
    m = $urandom_range(0, 9);
    if (m == 0) return '0;
    if (m == 1) return '1;
    if (m == 2) return W'(t[16:0]);
    return t[W-1:0];
  endfunction

  function automatic logic [CW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return CW'(a) * CW'(b);
  endfunction

  // One complete job. Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [CW-1:0] exp;
    int k;
    int e;
    exp = ref_mul(a, b);
    k = 0;
    while (!o_in_ready && k < 50) begin
      @(posedge clk); @(negedge clk); k++;
    end
    chk("in_ready_idle", CW'(o_in_ready), CW'(1'b1));
    i_in_valid = 1'b1;
    i_in_a     = a;
    i_in_b     = b;
    @(posedge clk); @(negedge clk);
    i_in_valid = 1'b0;
    i_in_a     = rnd_op();
    i_in_b     = rnd_op();
    chk("busy_after_accept", CW'(o_busy), CW'(1'b1));
    chk("in_ready_after_accept", CW'(o_in_ready), CW'(1'b0));
    e = 0;
    while (!o_out_valid && e < 200) begin
      i_out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk); e++;
    end
    i_out_ready = 1'b0;
    chk("out_valid_rise", CW'(o_out_valid), CW'(1'b1));
    chk("latency", CW'(e + 1), CW'(LAT));
    chk("out_c", o_out_c, exp);
    for (int s = 0; s < stall; s++) begin
      i_in_valid = 1'b1;
      i_in_a     = rnd_op();
      i_in_b     = rnd_op();
      @(posedge clk); @(negedge clk);
      chk("stall_out_valid", CW'(o_out_valid), CW'(1'b1));
      chk("stall_out_c", o_out_c, exp);
      chk("stall_in_ready", CW'(o_in_ready), CW'(1'b0));
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    i_out_ready = 1'b0;
    chk("out_valid_drop", CW'(o_out_valid), CW'(1'b0));
    chk("busy_drop", CW'(o_busy), CW'(1'b0));
    chk("in_ready_return", CW'(o_in_ready), CW'(1'b1));
  endtask

  initial begin
    logic [CW-1:0] q[$];
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int cyc;
    int last;
    int got;
    int e;

    n_checks    = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    i_in_a      = '0;
    i_in_b      = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", CW'(o_out_valid), CW'(1'b0));
    chk("rst_out_c", o_out_c, '0);
    chk("rst_busy", CW'(o_busy), CW'(1'b0));
    chk("rst_in_ready", CW'(o_in_ready), CW'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases.
    run_job('1, '1, 0);
    run_job('0, '1, 0);
    run_job(W'(1), W'(68'h5_A5A5_A5A5_A5A5_A5A5), 0);
    run_job('1, W'(1), 5);
    run_job(W'(68'h8_0000_0000_0000_0001), W'(68'hF_FFFF_0000_FFFF_0001), 2);

    // Back-to-back jobs with in_valid and out_ready held high.
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    cyc  = 0;
    last = -1;
    got  = 0;
    while (got < 6 && cyc < 400) begin
      if (o_out_valid) begin
        if (q.size() > 0) chk("b2b_out_c", o_out_c, q.pop_front());
        else chk("b2b_queue", CW'(q.size()), CW'(1));
        if (last >= 0) chk("b2b_period", CW'(cyc - last), CW'(PER));
        last = cyc;
        got++;
      end
      if (o_in_ready) begin
        a = rnd_op();
        b = rnd_op();
        i_in_a = a;
        i_in_b = b;
        q.push_back(ref_mul(a, b));
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    chk("b2b_count", CW'(got), CW'(6));
    @(posedge clk); @(negedge clk);

    // Reset asserted in MUL at (i,j)=(2,1).
    i_in_valid = 1'b1;
    i_in_a     = rnd_op();
    i_in_b     = rnd_op();
    @(posedge clk); @(negedge clk);
    i_in_valid = 1'b0;
    for (e = 0; e < 9; e++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", CW'(o_out_valid), CW'(1'b0));
    chk("midrst_out_c", o_out_c, '0);
    chk("midrst_busy", CW'(o_busy), CW'(1'b0));
    chk("midrst_in_ready", CW'(o_in_ready), CW'(1'b1));
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(W'(68'h1_2345_6789_ABCD_EF01), W'(68'hF_EDCB_A987_6543_210F), 1);

    // Random operands with random output stalls.
    for (int n = 0; n < 1000; n++) begin
      run_job(rnd_op(), rnd_op(), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
